// File: rtl/gate_tt_checker.sv
// gate_tt_checker: sweeps every input vector into a gate under test and checks its output against a truth table
module gate_tt_checker #(
    parameter int N_IN = 2,
    parameter int SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXPECT = 4'b0111
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dut_out,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;
    state_t state;
    logic [SW-1:0] settle_cnt;
    logic miss;
    // stim doubles as the vector index; case-inequality makes X/Z count as a miss
    assign miss = dut_out !== EXPECT[stim];
    assign pass = done && err_count == '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stim       <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= HOLD;
                    stim       <= '0;
                    settle_cnt <= '0;
                    err_count  <= '0;
                    fail_valid <= 1'b0;
                    fail_vec   <= '0;
                    done       <= 1'b0;
                    busy       <= 1'b1;
                end
                HOLD: begin
                    settle_cnt <= settle_cnt + SW'(1);
                    if (settle_cnt == SW'(SETTLE - 1)) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (miss) begin
                        err_count <= err_count + (N_IN + 1)'(1);
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= stim;
                        end
                    end
                    if (stim == {N_IN{1'b1}}) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        stim       <= stim + N_IN'(1);
                        settle_cnt <= '0;
                        state      <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker: directed checks of the sweep sequencer around modelled 2- and 3-input gates
module tb_gate_tt_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start2 = 1'b0;
    logic start3 = 1'b0;
    logic dut_out2, dut_out3;
    logic [1:0] stim2, fvec2;
    logic [2:0] err2, stim3, fvec3;
    logic [3:0] err3;
    logic busy2, done2, pass2, fv2;
    logic busy3, done3, pass3, fv3;
    int mode2 = 0;
    int mode3 = 0;
    int checks = 0;
    int failures = 0;
    logic probe = 1'bx;
    bit probe_2s;

    always #5 clk = ~clk;

    // mode2: 0 NAND, 1 stuck-at-0, 2 AND
    always_comb dut_out2 = mode2 == 2 ? &stim2 : mode2 == 1 ? 1'b0 : ~&stim2;
    // mode3: 0 NAND3, 1 wrong 1 at 111, 2 unknown at 111
    always_comb dut_out3 = (mode3 != 0 && stim3 == 3'b111) ? (mode3 == 1 ? 1'b1 : 1'bx) : ~&stim3;

    gate_tt_checker u2 (
        .clk(clk), .rst(rst), .start(start2), .dut_out(dut_out2), .stim(stim2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .fail_valid(fv2), .fail_vec(fvec2)
    );

    gate_tt_checker #(.N_IN(3), .SETTLE(1), .EXPECT(8'h7F)) u3 (
        .clk(clk), .rst(rst), .start(start3), .dut_out(dut_out3), .stim(stim3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .fail_vec(fvec3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit three, input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            step();
            if (three ? done3 : done2) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start2 = 1'b1;
        step();
        step();
        checks++;
        if ({stim2, busy2, done2, pass2, err2, fv2, fvec2} !== 11'b0) begin
            failures++;
            $display("FAIL reset_u2: got %b want all zero", {stim2, busy2, done2, pass2, err2, fv2, fvec2});
        end
        checks++;
        if ({stim3, busy3, done3, pass3, err3, fv3, fvec3} !== 15'b0) begin
            failures++;
            $display("FAIL reset_u3: got %b want all zero", {stim3, busy3, done3, pass3, err3, fv3, fvec3});
        end
        rst = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic test_nand();
        int cyc;
        mode2 = 0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        checks++;
        if ({busy2, done2, stim2} !== 4'b1000) begin
            failures++;
            $display("FAIL nand_accept: busy/done/stim got %b want 1000", {busy2, done2, stim2});
        end
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k < 12 && k % 3 == 0) begin
                checks++;
                if (stim2 !== 2'(k / 3)) begin
                    failures++;
                    $display("FAIL nand_stim_k%0d: got %0d want %0d", k, stim2, k / 3);
                end
            end
            if (done2) begin
                cyc = k;
                break;
            end
        end
        checks++;
        if (cyc !== 12) begin
            failures++;
            $display("FAIL nand_done_cycle: got %0d want 12", cyc);
        end
        checks++;
        if ({pass2, err2, fv2, fvec2, busy2, stim2} !== 10'b1_000_0_00_0_11) begin
            failures++;
            $display("FAIL nand_result: pass/err/fv/fvec/busy/stim got %b want 1000000011", {pass2, err2, fv2, fvec2, busy2, stim2});
        end
    endtask

    task automatic test_stuck0();
        int cyc;
        mode2 = 1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        wait_done(1'b0, 40, cyc);
        checks++;
        if (cyc !== 12) begin
            failures++;
            $display("FAIL stuck0_done_cycle: got %0d want 12", cyc);
        end
        checks++;
        if ({pass2, err2, fv2, fvec2} !== 7'b0_011_1_00) begin
            failures++;
            $display("FAIL stuck0_result: pass/err/fv/fvec got %b want 0011100", {pass2, err2, fv2, fvec2});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        mode2 = 2;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        wait_done(1'b0, 40, cyc);
        checks++;
        if ({err2, fv2, fvec2, pass2} !== 7'b100_1_00_0) begin
            failures++;
            $display("FAIL and_result: err/fv/fvec/pass got %b want 1001000", {err2, fv2, fvec2, pass2});
        end
        mode2 = 0;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        checks++;
        if ({err2, fv2, fvec2, done2, busy2} !== 8'b000_0_00_0_1) begin
            failures++;
            $display("FAIL restart_clear: err/fv/fvec/done/busy got %b want 00000001", {err2, fv2, fvec2, done2, busy2});
        end
        wait_done(1'b0, 40, cyc);
        checks++;
        if (cyc !== 12 || pass2 !== 1'b1 || err2 !== 3'd0) begin
            failures++;
            $display("FAIL restart_result: cyc=%0d pass=%b err=%0d want 12/1/0", cyc, pass2, err2);
        end
    endtask

    task automatic test_rst_mid();
        int cyc;
        mode2 = 1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        repeat (7) step();
        checks++;
        if ({stim2, busy2, err2} !== 6'b10_1_010) begin
            failures++;
            $display("FAIL mid_before_rst: stim/busy/err got %b want 101010", {stim2, busy2, err2});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({stim2, busy2, done2, err2, fv2, fvec2} !== 10'b0) begin
            failures++;
            $display("FAIL mid_rst_clear: stim/busy/done/err/fv/fvec got %b want 0", {stim2, busy2, done2, err2, fv2, fvec2});
        end
        mode2 = 0;
        start2 = 1'b1;
        step();
        cyc = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 4) begin
                checks++;
                if (stim2 !== 2'd1 || busy2 !== 1'b1) begin
                    failures++;
                    $display("FAIL held_start_no_restart: stim=%0d busy=%b want 1/1", stim2, busy2);
                end
            end
            if (done2) begin
                cyc = k;
                break;
            end
        end
        start2 = 1'b0;
        checks++;
        if (cyc !== 12 || pass2 !== 1'b1) begin
            failures++;
            $display("FAIL held_start_result: cyc=%0d pass=%b want 12/1", cyc, pass2);
        end
    endtask

    task automatic test_n3();
        int cyc;
        mode3 = 0;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        wait_done(1'b1, 60, cyc);
        checks++;
        if (cyc !== 16) begin
            failures++;
            $display("FAIL n3_done_cycle: got %0d want 16", cyc);
        end
        checks++;
        if ({pass3, err3, fv3, stim3} !== 9'b1_0000_0_111) begin
            failures++;
            $display("FAIL n3_result: pass/err/fv/stim got %b want 100000111", {pass3, err3, fv3, stim3});
        end
        mode3 = 1;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        wait_done(1'b1, 60, cyc);
        checks++;
        if (cyc !== 16 || {pass3, err3, fv3, fvec3} !== 9'b0_0001_1_111) begin
            failures++;
            $display("FAIL n3_last_wrong: cyc=%0d pass/err/fv/fvec got %b want 16 / 000011111", cyc, {pass3, err3, fv3, fvec3});
        end
        mode3 = 2;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        wait_done(1'b1, 60, cyc);
        probe_2s = probe;
        if (probe !== logic'(probe_2s)) begin
            checks++;
            if (err3 !== 4'd1 || fvec3 !== 3'b111) begin
                failures++;
                $display("FAIL n3_unknown_out: err=%0d fvec=%b want 1/111", err3, fvec3);
            end
        end
        mode3 = 0;
    endtask

    initial begin
        test_reset();
        test_nand();
        test_stuck0();
        test_back_to_back();
        test_rst_mid();
        test_n3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
Self-checking truth-table sequencer that drives every input combination into a small combinational gate under test (NAND, NOR, switch-level or gate-level) and samples the gate's output. It compares each sample against a parameterised expected truth table, counts mismatches and latches the first failing vector. It sits directly around the gate: its stimulus bus feeds the gate inputs, and the gate output returns on dut_out. This allows exhaustive gate checks to run in synthesizable or self-checking regression without hand-written per-vector stimulus.

Parameters:
N_IN, 2, number of gate inputs (1..4); stim[N_IN-1] is the MSB, so for N_IN=2 stim = {a,b}
SETTLE, 2, cycles each vector is held before sampling (>=1)
EXPECT, 4'b0111, expected output truth table, width 2**N_IN; EXPECT[v] is the required dut_out for stim==v (default = 2-input NAND)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a sweep
dut_out  input  1  output of the gate under test
stim  output  N_IN  registered input vector driven to the gate
busy  output  1  high while a sweep is in progress
done  output  1  high once a sweep has completed, until the next start or rst
pass  output  1  valid when done=1; high iff err_count==0
err_count  output  N_IN+1  number of mismatching vectors in the last sweep (max 2**N_IN, no saturation needed)
fail_valid  output  1  high once at least one mismatch has been seen in the current or last sweep
fail_vec  output  N_IN  first mismatching vector; 0 when fail_valid=0

Behaviour:
- All state is registered; the only combinational output is pass, which is decoded from registered state.
- Reset: at the rst edge, state=IDLE and every output is cleared: stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, internal vector/settle counters=0. rst has priority over start.
- States: IDLE, HOLD, SAMPLE, DONE.
- IDLE, or DONE, with start=1 -> HOLD next cycle. On that edge: vec=0, stim=0, settle_cnt=0, err_count=0, fail_valid=0, fail_vec=0, done=0, busy=1.
- HOLD: settle_cnt increments each cycle. When settle_cnt==SETTLE-1 -> SAMPLE; stim is unchanged during HOLD.
- SAMPLE (one cycle): compare dut_out with EXPECT[vec].
  - On mismatch: err_count+1. If fail_valid=0, set fail_valid=1 and fail_vec=vec. Later mismatches do not overwrite fail_vec.
  - If vec==2**N_IN-1 -> DONE: busy=0, done=1.
  - Otherwise: vec+1, stim=vec+1, settle_cnt=0 -> HOLD.
- Timing: each vector occupies exactly SETTLE+1 cycles. done rises 2**N_IN*(SETTLE+1) cycles after the edge that accepted start. For defaults this is 12 cycles.
- DONE: outputs hold; stim holds at the last vector. start restarts the sweep exactly as from IDLE, clearing the results.
- start while busy=1 is ignored: no restart and no effect on counters.
- dut_out is sampled only in SAMPLE; its value during HOLD is don't-care, so glitches while the gate settles cannot be recorded.
- rst mid-sweep aborts immediately to the reset values. No partial result is reported, and a new start begins again at vector 0.
- X/Z on dut_out during SAMPLE counts as a mismatch: use case-inequality, not logical equality.

Test Plan:
- Defaults, correct 2-input NAND connected, single start pulse -> stim steps 00,01,10,11 (3 cycles each); done=1 exactly 12 cycles after start; pass=1, err_count=0, fail_valid=0.
- Defaults, dut_out tied 0 -> done after 12 cycles; err_count=3, pass=0, fail_valid=1, fail_vec=2'b00.
- Defaults, AND gate connected instead of NAND -> err_count=4, fail_vec=2'b00. Then swap in a correct NAND and pulse start in DONE -> results cleared on the start edge; next sweep ends with pass=1, err_count=0.
- Defaults, rst asserted during the HOLD of vector 2'b10 -> next edge: stim=0, busy=0, done=0, err_count=0. start held high throughout the following sweep -> no restarts; done still at the 12-cycle mark.
- N_IN=3, SETTLE=1, EXPECT=8'h7F, 3-input NAND connected -> 8 vectors, done 16 cycles after start, pass=1. A dut_out=1'bz at stim=3'b111 -> err_count=1, fail_vec=3'b111.
